// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/lap/clear controller with an MM:SS BCD count.
// Consumes the divider's one-second tick and drives the divider's pause.
module stopwatch_ctrl #(
   parameter int unsigned MAX_MIN = 59
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start_stop,
   input  logic       lap,
   input  logic       clear,
   output logic       pause,
   output logic       running,
   output logic       lap_active,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       wrap
);

   typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} state_t;

   localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
   localparam logic [3:0] MAX_MO = 4'(MAX_MIN % 10);

   state_t     state_q, state_d;
   logic [3:0] so_q, st_q, mo_q, mt_q;
   logic [3:0] so_d, st_d, mo_d, mt_d;
   logic [3:0] snap_so_q, snap_st_q, snap_mo_q, snap_mt_q;
   logic [3:0] snap_so_d, snap_st_d, snap_mo_d, snap_mt_d;
   logic       wrap_q, wrap_d;
   logic       inc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         so_q      <= 4'd0;
         st_q      <= 4'd0;
         mo_q      <= 4'd0;
         mt_q      <= 4'd0;
         snap_so_q <= 4'd0;
         snap_st_q <= 4'd0;
         snap_mo_q <= 4'd0;
         snap_mt_q <= 4'd0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         so_q      <= so_d;
         st_q      <= st_d;
         mo_q      <= mo_d;
         mt_q      <= mt_d;
         snap_so_q <= snap_so_d;
         snap_st_q <= snap_st_d;
         snap_mo_q <= snap_mo_d;
         snap_mt_q <= snap_mt_d;
         wrap_q    <= wrap_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      so_d      = so_q;
      st_d      = st_q;
      mo_d      = mo_q;
      mt_d      = mt_q;
      snap_so_d = snap_so_q;
      snap_st_d = snap_st_q;
      snap_mo_d = snap_mo_q;
      snap_mt_d = snap_mt_q;
      wrap_d    = 1'b0;
      inc       = tick && (state_q == RUN || state_q == LAP);

      // Per-digit BCD ripple; the minute field wraps at MAX_MIN rather than 99.
      if (inc) begin
         if (so_q != 4'd9) begin
            so_d = so_q + 4'd1;
         end else begin
            so_d = 4'd0;
            if (st_q != 4'd5) begin
               st_d = st_q + 4'd1;
            end else begin
               st_d = 4'd0;
               if (mt_q == MAX_MT && mo_q == MAX_MO) begin
                  mo_d   = 4'd0;
                  mt_d   = 4'd0;
                  wrap_d = 1'b1;
               end else if (mo_q != 4'd9) begin
                  mo_d = mo_q + 4'd1;
               end else begin
                  mo_d = 4'd0;
                  mt_d = mt_q + 4'd1;
               end
            end
         end
      end

      case (state_q)
         IDLE: begin
            if (start_stop) state_d = RUN;
         end
         RUN: begin
            if (start_stop) begin
               state_d = STOP;
            end else if (lap) begin
               // Snapshot takes the pre-increment count.
               state_d   = LAP;
               snap_so_d = so_q;
               snap_st_d = st_q;
               snap_mo_d = mo_q;
               snap_mt_d = mt_q;
            end
         end
         LAP: begin
            if (start_stop)  state_d = STOP;
            else if (lap)    state_d = RUN;
         end
         STOP: begin
            if (clear) begin
               state_d = IDLE;
               so_d    = 4'd0;
               st_d    = 4'd0;
               mo_d    = 4'd0;
               mt_d    = 4'd0;
            end else if (start_stop) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pause      = (state_q == IDLE) || (state_q == STOP);
   assign running    = (state_q == RUN)  || (state_q == LAP);
   assign lap_active = (state_q == LAP);
   assign wrap       = wrap_q;

   assign sec_ones = lap_active ? snap_so_q : so_q;
   assign sec_tens = lap_active ? snap_st_q : st_q;
   assign min_ones = lap_active ? snap_mo_q : mo_q;
   assign min_tens = lap_active ? snap_mt_q : mt_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: directed walk plus randomized inputs,
// checked against a seconds-as-integer reference model.
module tb_stopwatch_ctrl;

   localparam int unsigned MAX_MIN = 59;
   localparam int TOTAL = (MAX_MIN + 1) * 60;

   localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_LAP = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0, tick = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
   logic       pause, running, lap_active, wrap;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;

   stopwatch_ctrl #(.MAX_MIN(MAX_MIN)) dut (
      .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop),
      .lap(lap), .clear(clear), .pause(pause), .running(running),
      .lap_active(lap_active), .sec_ones(sec_ones), .sec_tens(sec_tens),
      .min_ones(min_ones), .min_tens(min_tens), .wrap(wrap)
   );

   always #5 clk = ~clk;

   // {pause, running, lap_active, min_tens, min_ones, sec_tens, sec_ones, wrap}
   logic [19:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: elapsed seconds as a plain integer.
   int m_mode = M_IDLE;
   int m_cnt  = 0;
   int m_snap = 0;
   bit m_wrap = 1'b0;

   function automatic logic [19:0] pack_exp(int mode, int cnt, int snap, bit w);
      int d, mm, ss;
      d  = (mode == M_LAP) ? snap : cnt;
      mm = d / 60;
      ss = d % 60;
      return {(mode == M_IDLE || mode == M_STOP), (mode == M_RUN || mode == M_LAP),
              (mode == M_LAP), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), w};
   endfunction

   task automatic step(input bit r, input bit t, input bit s, input bit l, input bit c);
      int nc;
      @(negedge clk);
      reset = r; tick = t; start_stop = s; lap = l; clear = c;
      if (r) begin
         m_mode = M_IDLE; m_cnt = 0; m_snap = 0; m_wrap = 1'b0;
      end else begin
         nc = m_cnt;
         m_wrap = 1'b0;
         if (t && (m_mode == M_RUN || m_mode == M_LAP)) begin
            if (m_cnt == TOTAL - 1) begin
               nc = 0; m_wrap = 1'b1;
            end else begin
               nc = m_cnt + 1;
            end
         end
         case (m_mode)
            M_IDLE: if (s) m_mode = M_RUN;
            M_RUN: begin
               if (s) m_mode = M_STOP;
               else if (l) begin m_mode = M_LAP; m_snap = m_cnt; end
            end
            M_LAP: begin
               if (s) m_mode = M_STOP;
               else if (l) m_mode = M_RUN;
            end
            default: begin
               if (c) begin m_mode = M_IDLE; nc = 0; end
               else if (s) m_mode = M_RUN;
            end
         endcase
         m_cnt = nc;
      end
      exp_q.push_back(pack_exp(m_mode, m_cnt, m_snap, m_wrap));
   endtask

   // Monitor: every cycle is an output beat; compare it against the queued expectation.
   initial begin
      logic [19:0] e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pause, running, lap_active, min_tens, min_ones, sec_tens, sec_ones, wrap};
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL outs t=%0t got p=%b r=%b l=%b %h%h:%h%h w=%b expected p=%b r=%b l=%b %h%h:%h%h w=%b",
                        $time, a[19], a[18], a[17], a[16:13], a[12:9], a[8:5], a[4:1], a[0],
                        e[19], e[18], e[17], e[16:13], e[12:9], e[8:5], e[4:1], e[0]);
            end
         end
      end
   end

   initial begin
      step(1, 0, 0, 0, 0);
      repeat (3) step(0, 1, 0, 0, 0);          // ticks ignored in IDLE
      step(0, 0, 1, 0, 0);
      repeat (75) step(0, 1, 0, 0, 0);         // 01:15
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 1);                     // clear to IDLE
      step(0, 1, 1, 0, 0);                     // tick on entry edge not counted
      repeat (10) step(0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0);                     // lap at 00:10
      repeat (5) step(0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0);                     // release: 00:15
      repeat (5) step(0, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0);                     // stop with tick: 00:21
      repeat (3) step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0);
      repeat (TOTAL - 2) step(0, 1, 0, 0, 0);  // 59:58
      repeat (2) step(0, 1, 0, 0, 0);          // 59:59 then 00:00 with wrap
      repeat (3) step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      repeat (150) step(0, 1, 0, 0, 0);        // 02:30
      step(0, 1, 0, 1, 0);                     // lap with same-edge tick
      repeat (4) step(0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);                     // reset in LAP
      step(0, 0, 1, 0, 0);
      repeat (4) step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 1);                     // clear beats start_stop in STOP
      step(0, 0, 1, 1, 0);
      repeat (6) step(0, 1, 0, 1, 0);          // lap held high toggles every edge
      step(0, 1, 1, 1, 0);                     // start_stop beats lap
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 499) == 0), $urandom_range(0, 1),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 7) == 0));
      end
      @(posedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
